opc_uart_io: RTL

OPC_UART_IO -- requirements
Module: opc_uart_io

---
 rtl/opc_uart_io.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/opc_uart_io.sv
// rtl/opc_uart_io.sv - CPU-bus mapped 8N1 UART with TX/RX byte queues
// UART_FIFO_EN selects 4-entry queues; without it each direction holds one byte.
module opc_uart_io_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);
  localparam logic [1:0] LAST    = 2'(DEPTH - 1);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic       push_ok, pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == 3'd0);
  // A push into a full queue is lost even when a pop frees a slot that same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
      count <= count + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end
endmodule

module opc_uart_io #(
  parameter logic [11:0] BASE_ADDR = 12'hFF0,
  parameter int          CLK_DIV   = 16
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [11:0] address,
  inout  wire logic [7:0] data,
  input  logic        rnw,
  input  logic        rxd,
  output logic        txd
);
`ifdef UART_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [7:0] BIT_END  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HALF_END = 8'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
  logic [7:0]  tx_cnt, tx_cnt_n, tx_shift, tx_shift_n, tx_head;
  logic [7:0]  rx_cnt, rx_cnt_n, rx_shift, rx_shift_n, rx_head, rd_data;
  logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n, tx_count, rx_count;
  logic        sel, rd_en, wr_en, status_wr, tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_full, tx_q_empty, rx_full, rx_empty, rx_overrun, frame_err, frame_set;
  logic        rx_s1, rx_s2, rx_prev;
  logic [1:0]  offset;

  assign sel       = (address[11:2] == BASE_ADDR[11:2]);
  assign offset    = address[1:0];
  assign rd_en     = sel & rnw;
  assign wr_en     = sel & ~rnw;
  assign data      = rd_en ? rd_data : 8'hzz;
  assign tx_push   = wr_en & (offset == 2'd0);
  assign status_wr = wr_en & (offset == 2'd1);
  assign rx_pop    = rd_en & (offset == 2'd0);

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      2'd0:    rd_data = rx_empty ? 8'h00 : rx_head;
      2'd1:    rd_data = {3'b000, frame_err, tx_q_empty & (tx_state == ST_IDLE),
                          rx_overrun, tx_full, ~rx_empty};
      2'd2:    rd_data = {1'b0, tx_count, 1'b0, rx_count};
      default: rd_data = 8'h00;
    endcase
  end

  opc_uart_io_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset_b(reset_b), .push(tx_push), .push_data(data), .pop(tx_pop),
    .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_q_empty)
  );

  opc_uart_io_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset_b(reset_b), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state   <= ST_IDLE;
      tx_cnt     <= 8'd0;
      tx_shift   <= 8'd0;
      tx_bit     <= 3'd0;
      rx_state   <= ST_IDLE;
      rx_cnt     <= 8'd0;
      rx_shift   <= 8'd0;
      rx_bit     <= 3'd0;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      // A new event wins over a same-cycle clear so it is never lost.
      if (rx_push & rx_full)        rx_overrun <= 1'b1;
      else if (status_wr & data[2]) rx_overrun <= 1'b0;
      if (frame_set)                frame_err  <= 1'b1;
      else if (status_wr & data[4]) frame_err  <= 1'b0;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 8'd1;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    tx_pop     = 1'b0;
    txd        = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_n = 8'd0;
        if (!tx_q_empty) begin
          tx_state_n = ST_START;
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
        end
      end
      ST_START: begin
        txd = 1'b0;
        if (tx_cnt == BIT_END) begin
          tx_state_n = ST_DATA;
          tx_cnt_n   = 8'd0;
          tx_bit_n   = 3'd0;
        end
      end
      ST_DATA: begin
        txd = tx_shift[0];
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = 8'd0;
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = ST_STOP;
        end
      end
      default: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = 8'd0;
          // Chain straight into the next start bit so frames leave without a gap.
          if (!tx_q_empty) begin
            tx_state_n = ST_START;
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
          end else begin
            tx_state_n = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 8'd1;
    rx_shift_n = rx_shift;
    rx_bit_n   = rx_bit;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        rx_cnt_n = 8'd0;
        if (rx_prev & ~rx_s2) rx_state_n = ST_START;
      end
      ST_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = 8'd0;
          rx_bit_n   = 3'd0;
          rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = 8'd0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = ST_STOP;
        end
      end
      default: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = 8'd0;
          rx_state_n = ST_IDLE;
          rx_push    = rx_s2;
          frame_set  = ~rx_s2;
        end
      end
    endcase
  end
endmodule
